// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - uart_state_e : binary-encoded frame states (IDLE=0 .. CLEANUP=4)
//   - UART_CPB_*   : clock cycles per bit at 50 MHz for supported baud rates
//   - cnt_width()  : counter width for a given modulus (never below 1 bit)
package uart_pkg;

  localparam int UART_STATE_SIZE = 3;

  typedef enum logic [UART_STATE_SIZE-1:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

  localparam int UART_CPB_115200 = 434;
  localparam int UART_CPB_57600  = 868;
  localparam int UART_CPB_19200  = 2604;
  localparam int UART_CPB_9600   = 5208;

  // Width of a counter running 0..n-1; a 1-bit floor keeps n=1 legal.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-side and line-side signals of the UART transmitter.
//   UART_TX_newData_InHigh : start strobe (master -> slave)
//   UART_TX_data_In        : byte to send (master -> slave)
//   UART_TX_tx_Out         : serial line, idle high (slave -> master)
//   UART_TX_busy_Out       : frame in progress (slave -> master)
//   UART_TX_done_Out       : one-cycle end-of-frame pulse (slave -> master)
interface uart_tx_if #(
  parameter int DATAWIDTH_BUS = 8
) ();
  logic                     UART_TX_newData_InHigh;
  logic [DATAWIDTH_BUS-1:0] UART_TX_data_In;
  logic                     UART_TX_tx_Out;
  logic                     UART_TX_busy_Out;
  logic                     UART_TX_done_Out;

  modport master (
    output UART_TX_newData_InHigh,
    output UART_TX_data_In,
    input  UART_TX_tx_Out,
    input  UART_TX_busy_Out,
    input  UART_TX_done_Out
  );

  modport slave (
    input  UART_TX_newData_InHigh,
    input  UART_TX_data_In,
    output UART_TX_tx_Out,
    output UART_TX_busy_Out,
    output UART_TX_done_Out
  );
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..CLOCK_PER_BIT-1 while enabled and flags the
// last count of each bit period.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 (wins over enable)
//   enable     : advance the count this cycle
//   tick       : high in the final cycle of a bit period (enable && count==last)
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_width(CLOCK_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLOCK_PER_BIT - 1);

  logic [CW-1:0] count_r;

  assign tick = enable && (count_r == LAST);

  // Bit-period counter; wraps to 0 on the terminal count, never past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      if (count_r == LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + 1'b1;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style UART transmitter. A strobe accepted in IDLE captures the
// byte; the frame is start bit (0), DATAWIDTH_BUS data bits LSB first, stop
// bit (1), then a one-cycle CLEANUP state that pulses done.
//   UART_TX_CLOCK_50    : system clock, rising edge
//   UART_TX_RESET_InLow : asynchronous reset, active-low
//   bus                 : uart_tx_if slave (strobe/data in, tx/busy/done out)
// All three outputs are flops whose next values are decoded from the
// next-state values, so tx never glitches and changes with the state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = 434,
  parameter int DATAWIDTH_BUS = 8,
  parameter int STATE_SIZE    = 3
) (
  input  logic    UART_TX_CLOCK_50,
  input  logic    UART_TX_RESET_InLow,
  uart_tx_if.slave bus
);

  if (STATE_SIZE != UART_STATE_SIZE) begin : g_state_size_check
    $error("uart_tx: STATE_SIZE must match uart_pkg state encoding width");
  end

  localparam int IW = cnt_width(DATAWIDTH_BUS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATAWIDTH_BUS - 1);

  uart_state_e              state_r, state_s;
  logic [DATAWIDTH_BUS-1:0] shift_r, shift_s;
  logic [IW-1:0]            idx_r, idx_s;
  logic                     tx_r, tx_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;
  logic                     tick_s;
  logic                     cnt_en_s;
  logic                     cnt_clr_s;

  // The counter only runs during timed bit periods and sits at 0 otherwise,
  // so the first START cycle always sees count 0.
  assign cnt_en_s  = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP);
  assign cnt_clr_s = !cnt_en_s;

  uart_baud_counter #(
    .CLOCK_PER_BIT(CLOCK_PER_BIT)
  ) u_baud (
    .clk    (UART_TX_CLOCK_50),
    .rst_n  (UART_TX_RESET_InLow),
    .clear  (cnt_clr_s),
    .enable (cnt_en_s),
    .tick   (tick_s)
  );

  // State, shift register, bit index and output flops.
  always_ff @(posedge UART_TX_CLOCK_50 or negedge UART_TX_RESET_InLow) begin
    if (!UART_TX_RESET_InLow) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      idx_r   <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      idx_r   <= idx_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic, then output decode from the next state.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    tx_s    = 1'b1;
    busy_s  = 1'b0;
    done_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // The strobe is only looked at here, so strobes mid-frame are dropped.
        if (bus.UART_TX_newData_InHigh) begin
          shift_s = bus.UART_TX_data_In;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          idx_s   = '0;
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_s = shift_r >> 1;
          if (idx_r == LAST_IDX) begin
            state_s = ST_STOP;
          end else begin
            idx_s = idx_r + 1'b1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          state_s = ST_CLEANUP;
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_CLEANUP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_CLEANUP);
    case (state_s)
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = shift_s[0];
      default:  tx_s = 1'b1;
    endcase
  end

  assign bus.UART_TX_tx_Out   = tx_r;
  assign bus.UART_TX_busy_Out = busy_r;
  assign bus.UART_TX_done_Out = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a scoreboard. Stimulus pushes the
// expected byte; line monitors decode each frame at bit centres and compare.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB  = 4;
  localparam int CPB2 = UART_CPB_115200;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b1;

  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  int         fall_q[$];

  uart_tx_if #(.DATAWIDTH_BUS(8)) bus ();
  uart_tx_if #(.DATAWIDTH_BUS(8)) bus2 ();

  uart_tx #(.CLOCK_PER_BIT(CPB), .DATAWIDTH_BUS(8), .STATE_SIZE(3)) dut (
    .UART_TX_CLOCK_50    (clk),
    .UART_TX_RESET_InLow (rst_n),
    .bus                 (bus)
  );

  uart_tx #(.CLOCK_PER_BIT(CPB2), .DATAWIDTH_BUS(8), .STATE_SIZE(3)) dut2 (
    .UART_TX_CLOCK_50    (clk),
    .UART_TX_RESET_InLow (rst_n),
    .bus                 (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.UART_TX_done_Out === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? bus2.UART_TX_tx_Out : bus.UART_TX_tx_Out;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? bus2.UART_TX_done_Out : bus.UART_TX_done_Out;
  endfunction

  // Called at the negedge where the start bit was first seen low.
  task automatic rx_frame(input bit sel, input int cpb, output logic [7:0] d);
    repeat (cpb / 2) @(negedge clk);
    chk("start_bit", line_of(sel), 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      d[i] = line_of(sel);
    end
    repeat (cpb) @(negedge clk);
    chk("stop_bit", line_of(sel), 1'b1);
    repeat (cpb - cpb / 2) @(negedge clk);
    chk("done_pulse", done_of(sel), 1'b1);
  endtask

  task automatic mon_loop(input bit sel, input int cpb);
    logic prev, cur;
    logic [7:0] d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      cur = line_of(sel);
      if (prev === 1'b1 && cur === 1'b0 && (sel || mon_en)) begin
        if (!sel) fall_q.push_back(cyc);
        rx_frame(sel, cpb, d);
        if (sel ? (exp2_q.size() == 0) : (exp_q.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %0h expected none (cycle %0d)", d, cyc);
        end else if (sel) begin
          chk("loop_byte", d, exp2_q.pop_front());
        end else begin
          chk("frame_byte", d, exp_q.pop_front());
        end
        cur = line_of(sel);
      end
      prev = cur;
    end
  endtask

  initial mon_loop(1'b0, CPB);
  initial mon_loop(1'b1, CPB2);

  task automatic send(input bit sel, input logic [7:0] b, input bit push);
    @(posedge clk);
    #1;
    if (sel) begin
      bus2.UART_TX_data_In = b;
      bus2.UART_TX_newData_InHigh = 1'b1;
      if (push) exp2_q.push_back(b);
    end else begin
      bus.UART_TX_data_In = b;
      bus.UART_TX_newData_InHigh = 1'b1;
      if (push) exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    if (sel) bus2.UART_TX_newData_InHigh = 1'b0;
    else     bus.UART_TX_newData_InHigh = 1'b0;
  endtask

  task automatic wait_drain(input bit sel, input int limit);
    int n = 0;
    while (n < limit && ((sel ? exp2_q.size() : exp_q.size()) != 0 ||
           (sel ? bus2.UART_TX_busy_Out : bus.UART_TX_busy_Out) !== 1'b0)) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < limit), 1'b1);
  endtask

  logic [9:0]  frame;
  logic [2:0]  exp_o;
  int          d0;
  bit          line_ok;
  logic [7:0]  loop_bytes [4];

  initial begin
    rst_n = 1'b0;
    bus.UART_TX_newData_InHigh  = 1'b0;
    bus.UART_TX_data_In         = 8'h00;
    bus2.UART_TX_newData_InHigh = 1'b0;
    bus2.UART_TX_data_In        = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.UART_TX_tx_Out, bus.UART_TX_busy_Out, bus.UART_TX_done_Out}, 3'b100);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 0x55 with cycle-exact line/busy/done checks over the whole frame.
    send(1'b0, 8'h55, 1'b1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 1; k <= 10 * CPB + 2; k++) begin
      @(negedge clk);
      exp_o[2] = ((k - 1) / CPB < 10) ? frame[(k - 1) / CPB] : 1'b1;
      exp_o[1] = (k <= 10 * CPB + 1);
      exp_o[0] = (k == 10 * CPB + 1);
      chk($sformatf("timing_k%0d", k),
          {bus.UART_TX_tx_Out, bus.UART_TX_busy_Out, bus.UART_TX_done_Out}, exp_o);
    end
    wait_drain(1'b0, 200);

    // 0xA3: centres must read 0,1,1,0,0,0,1,0,1,1.
    send(1'b0, 8'hA3, 1'b1);
    wait_drain(1'b0, 200);

    // Strobe with 0x0F mid-frame is ignored.
    d0 = done_cnt;
    send(1'b0, 8'hFF, 1'b1);
    repeat (18) @(posedge clk);
    send(1'b0, 8'h0F, 1'b0);
    wait_drain(1'b0, 200);
    repeat (30) @(negedge clk);
    chk("ignored_strobe_done_count", done_cnt - d0, 1);
    chk("ignored_strobe_no_frame", exp_q.size(), 0);

    // Strobe held high: three back-to-back 0x00 frames, 42 cycles apart.
    fall_q.delete();
    @(posedge clk);
    #1;
    bus.UART_TX_data_In = 8'h00;
    bus.UART_TX_newData_InHigh = 1'b1;
    repeat (3) exp_q.push_back(8'h00);
    repeat (100) @(posedge clk);
    #1 bus.UART_TX_newData_InHigh = 1'b0;
    wait_drain(1'b0, 300);
    chk("held_frame_count", fall_q.size(), 3);
    if (fall_q.size() >= 3) begin
      chk("held_period_1", fall_q[1] - fall_q[0], 10 * CPB + 2);
      chk("held_period_2", fall_q[2] - fall_q[1], 10 * CPB + 2);
    end

    // Reset during the third data bit.
    mon_en = 1'b0;
    d0 = done_cnt;
    send(1'b0, 8'hAA, 1'b0);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midframe_reset_outputs",
           {bus.UART_TX_tx_Out, bus.UART_TX_busy_Out, bus.UART_TX_done_Out}, 3'b100);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    line_ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.UART_TX_tx_Out !== 1'b1 || bus.UART_TX_busy_Out !== 1'b0) line_ok = 1'b0;
    end
    chk("post_reset_line_idle", line_ok, 1'b1);
    chk("post_reset_no_done", done_cnt - d0, 0);
    mon_en = 1'b1;
    send(1'b0, 8'h3C, 1'b1);
    wait_drain(1'b0, 200);

    // Loopback-rate instance at 115200 Bd.
    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h81;
    loop_bytes[3] = 8'h7E;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, loop_bytes[i], 1'b1);
      wait_drain(1'b1, 12 * CPB2);
    end

    chk("scoreboard_empty", exp_q.size() + exp2_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
